// File: rtl/invl_stats_timer.sv
// invl_stats_timer
// Interval timer and snapshot sequencer for the link-engine interval stats.
// It raises a one-cycle latch_clr strobe when the programmed period expires or
// when software forces it. The snapshot that results is then offered to the
// collector on a valid/ack handshake, together with a sequence number.
// An overrun is counted when an interval closes before the previous snapshot
// has been consumed.

module invl_stats_timer #(
    parameter int TMR_W = 32,
    parameter int SEQ_W = 16,
    parameter int OVR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             invl_en,
    input  logic [TMR_W-1:0] invl_period,
    input  logic             force_latch,
    input  logic             snap_ack,
    input  logic             ovr_clr,
    output logic             latch_clr,
    output logic             snap_valid,
    output logic [SEQ_W-1:0] snap_seq,
    output logic             snap_forced,
    output logic             ovr_flag,
    output logic [OVR_W-1:0] ovr_cnt
);

    // Snapshot sequencer states.
    localparam logic [1:0] ST_IDLE  = 2'd0;  // no snapshot outstanding
    localparam logic [1:0] ST_LATCH = 2'd1;  // counters latch/clear this cycle
    localparam logic [1:0] ST_VALID = 2'd2;  // snapshot stable, awaiting ack

    logic [TMR_W-1:0] tmr_q,       tmr_d;
    logic [1:0]       state_q,     state_d;
    logic [SEQ_W-1:0] seq_q,       seq_d;
    logic             forced_q,    forced_d;
    logic             ovr_flag_q,  ovr_flag_d;
    logic [OVR_W-1:0] ovr_cnt_q,   ovr_cnt_d;

    logic term;
    logic trig;
    logic ovr_ev;

    // The compare is >= rather than ==. If the period is lowered below the
    // current count, the interval then closes on the next cycle instead of
    // waiting for the timer to wrap.
    assign term = (tmr_q >= invl_period);
    assign trig = force_latch | (invl_en & term);

    // Interval timer: it is held at 0 while disabled, restarts on expiry, and
    // a force always restarts it so the next period is measured from the force.
    always_comb begin
        tmr_d = tmr_q + TMR_W'(1);
        if (force_latch || !invl_en || term) begin
            tmr_d = '0;
        end
    end

    // Sequencer next state. Every trigger lands in LATCH, so a closing interval
    // always produces a strobe, even when the old snapshot is still unread.
    always_comb begin
        state_d = state_q;
        ovr_ev  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (trig) begin
                    state_d = ST_LATCH;
                    ovr_ev  = 1'b1;
                end else begin
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (trig) begin
                    state_d = ST_LATCH;
                    ovr_ev  = ~snap_ack;
                end else if (snap_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequence number and the forced tag are captured together at each trigger.
    // Any trigger leaves VALID, so both values stay still while the collector
    // reads them.
    always_comb begin
        seq_d    = seq_q;
        forced_d = forced_q;
        if (trig) begin
            seq_d    = seq_q + SEQ_W'(1);
            forced_d = force_latch;
        end
    end

    // Overrun bookkeeping. A clear that coincides with an overrun keeps that
    // overrun, so it cannot be lost. The count saturates at all-ones.
    always_comb begin
        ovr_flag_d = ovr_flag_q;
        ovr_cnt_d  = ovr_cnt_q;
        if (ovr_clr) begin
            ovr_flag_d = ovr_ev;
            ovr_cnt_d  = ovr_ev ? OVR_W'(1) : '0;
        end else if (ovr_ev) begin
            ovr_flag_d = 1'b1;
            if (ovr_cnt_q != {OVR_W{1'b1}}) begin
                ovr_cnt_d = ovr_cnt_q + OVR_W'(1);
            end
        end
    end

    // State registers. Reset discards any pending snapshot immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q      <= '0;
            state_q    <= ST_IDLE;
            seq_q      <= '0;
            forced_q   <= 1'b0;
            ovr_flag_q <= 1'b0;
            ovr_cnt_q  <= '0;
        end else begin
            tmr_q      <= tmr_d;
            state_q    <= state_d;
            seq_q      <= seq_d;
            forced_q   <= forced_d;
            ovr_flag_q <= ovr_flag_d;
            ovr_cnt_q  <= ovr_cnt_d;
        end
    end

    // Outputs are decoded from registered state only.
    assign latch_clr   = (state_q == ST_LATCH);
    assign snap_valid  = (state_q == ST_VALID);
    assign snap_seq    = seq_q;
    assign snap_forced = forced_q;
    assign ovr_flag    = ovr_flag_q;
    assign ovr_cnt     = ovr_cnt_q;

endmodule

// File: tb/tb_invl_stats_timer.sv
// Testbench for invl_stats_timer. It combines directed scenarios with a
// randomized phase, and compares the DUT every cycle against a snapshot-level
// reference model.

module tb_invl_stats_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        invl_en = 1'b0;
    logic [31:0] invl_period = '0;
    logic        force_latch = 1'b0;
    logic        snap_ack = 1'b0;
    logic        ovr_clr = 1'b0;
    logic        latch_clr, snap_valid, snap_forced, ovr_flag;
    logic [15:0] snap_seq;
    logic [7:0]  ovr_cnt;

    int checks = 0;
    int errors = 0;

    invl_stats_timer dut (
        .clk(clk), .rst_n(rst_n), .invl_en(invl_en), .invl_period(invl_period),
        .force_latch(force_latch), .snap_ack(snap_ack), .ovr_clr(ovr_clr),
        .latch_clr(latch_clr), .snap_valid(snap_valid), .snap_seq(snap_seq),
        .snap_forced(snap_forced), .ovr_flag(ovr_flag), .ovr_cnt(ovr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, kept at the level of snapshots:
    //   m_strobe - a latch/clear strobe is being issued this cycle
    //   m_pend   - a snapshot exists that the collector has not consumed
    logic [31:0] m_tmr;
    bit          m_strobe, m_pend, m_forced, m_flag;
    int          m_seq, m_ovr;

    function automatic bit m_valid();
        return m_pend && !m_strobe;
    endfunction

    task automatic m_reset();
        m_tmr = 0; m_strobe = 0; m_pend = 0; m_forced = 0; m_flag = 0;
        m_seq = 0; m_ovr = 0;
    endtask

    task automatic m_update();
        bit term, trig, consumed, ovr;
        term     = invl_en && (m_tmr >= invl_period);
        trig     = force_latch || term;
        consumed = m_valid() && snap_ack;
        ovr      = trig && m_pend && !consumed;
        m_tmr    = (force_latch || !invl_en || term) ? 0 : m_tmr + 1;
        if (trig) begin
            m_seq    = (m_seq + 1) % 65536;
            m_forced = force_latch;
        end
        if (ovr_clr) begin
            m_flag = ovr;
            m_ovr  = ovr ? 1 : 0;
        end else if (ovr) begin
            m_flag = 1;
            m_ovr  = (m_ovr < 255) ? m_ovr + 1 : 255;
        end
        m_pend   = trig || (m_pend && !consumed);
        m_strobe = trig;
    endtask

    task automatic cmp_all();
        chk("latch_clr",   latch_clr,   m_strobe);
        chk("snap_valid",  snap_valid,  m_valid());
        chk("snap_seq",    snap_seq,    m_seq);
        chk("snap_forced", snap_forced, m_forced);
        chk("ovr_flag",    ovr_flag,    m_flag);
        chk("ovr_cnt",     ovr_cnt,     m_ovr);
    endtask

    // One clock: the inputs were set after the previous negedge. The model
    // updates at the posedge and the outputs are compared at the negedge.
    task automatic step();
        @(posedge clk);
        m_update();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic zero_inputs();
        invl_en = 0; force_latch = 0; snap_ack = 0; ovr_clr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        zero_inputs();
        m_reset();
        #1;
        chk("rst_latch_clr", latch_clr, 0);
        chk("rst_valid",     snap_valid, 0);
        chk("rst_seq",       snap_seq, 0);
        chk("rst_forced",    snap_forced, 0);
        chk("rst_flag",      ovr_flag, 0);
        chk("rst_cnt",       ovr_cnt, 0);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        int first;
        m_reset();
        do_reset();

        // Periodic operation with period 9, acking every snapshot.
        // The first strobe appears in cycle 11, i.e. after the 10th edge.
        invl_en = 1; invl_period = 9; first = -1;
        for (int i = 1; i <= 40; i++) begin
            snap_ack = m_valid();
            step();
            if (latch_clr && first < 0) first = i;
        end
        chk("first_latch_step", first, 10);
        chk("seq_after_40", snap_seq, 4);
        chk("no_ovr_acked", ovr_cnt, 0);

        // Force while disabled: strobe next cycle, valid the cycle after.
        zero_inputs();
        for (int i = 0; i < 3; i++) begin snap_ack = m_valid(); step(); end
        snap_ack = 0;
        force_latch = 1; step(); force_latch = 0;
        chk("force_strobe", latch_clr, 1);
        step();
        chk("force_valid", snap_valid, 1);
        chk("force_tag", snap_forced, 1);
        snap_ack = 1; step(); snap_ack = 0;

        // Period 4 with no ack: the overrun count has to saturate.
        invl_en = 1; invl_period = 4;
        for (int i = 0; i < 1400; i++) step();
        chk("ovr_saturate", ovr_cnt, 255);
        chk("ovr_flag_set", ovr_flag, 1);

        // Period 0: the strobe is held, and ovr_clr with an overrun leaves 1.
        invl_period = 0;
        step(); step();
        chk("p0_latch_held", latch_clr, 1);
        ovr_clr = 1; step(); ovr_clr = 0;
        chk("clr_with_ovr", ovr_cnt, 1);
        step();
        chk("p0_ovr_inc", ovr_cnt, 2);

        // Lower the period below the running count: it fires on the next cycle.
        zero_inputs();
        for (int i = 0; i < 4; i++) begin snap_ack = m_valid(); step(); end
        snap_ack = 0; ovr_clr = 1; step(); ovr_clr = 0;
        invl_en = 1; invl_period = 100;
        for (int i = 0; i < 50; i++) step();
        chk("tmr_mid_no_latch", latch_clr, 0);
        invl_period = 3; step();
        chk("lowered_period_fire", latch_clr, 1);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 64) == 0) invl_period = $urandom_range(0, 12);
            invl_en     = ($urandom % 8) != 0;
            force_latch = ($urandom % 16) == 0;
            snap_ack    = ($urandom % 2) == 0;
            ovr_clr     = ($urandom % 32) == 0;
            step();
        end

        // Reset in the middle of VALID with five overruns recorded.
        do_reset();
        invl_en = 1; invl_period = 4;
        for (int i = 0; i < 200 && !(m_ovr == 5 && m_valid()); i++) step();
        chk("pre_rst_cnt", ovr_cnt, 5);
        chk("pre_rst_valid", snap_valid, 1);
        do_reset();
        invl_en = 1; invl_period = 2;
        for (int i = 0; i < 4; i++) step();
        chk("post_rst_seq", snap_seq, 1);
        chk("post_rst_valid", snap_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
